// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM port arbiter.
package vram_pkg;

    localparam int VRAM_AW   = 11;
    localparam int VRAM_DW   = 9;
    localparam int VRAM_NREQ = 3;

    localparam int REQ_CLEAR  = 0;
    localparam int REQ_SCROLL = 1;
    localparam int REQ_CHAR   = 2;

    localparam logic [VRAM_AW-1:0] VRAM_LAST_ADDR = 11'h7FF;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter_pick.sv
// Combinational one-hot picker: first set request found searching upward
// from start, wrapping. Tying start to 0 gives fixed lowest-index priority.
module arb_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Three-way VRAM port arbiter with ownership lock and tagged read return.
// Define VRAM_ARB_RR_EN for round-robin selection instead of fixed priority.
import vram_pkg::*;

module vram_arbiter #(
    parameter int AW   = VRAM_AW,
    parameter int DW   = VRAM_DW,
    parameter int NREQ = VRAM_NREQ
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_din,
    input  logic [NREQ-1:0]   i_we,
    input  logic [NREQ-1:0]   i_ce,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_rvalid,
    output logic [DW-1:0]     o_rdata,
    output logic              o_busy,
    output logic [AW-1:0]     o_vram_addr,
    output logic [DW-1:0]     o_vram_din,
    output logic              o_vram_w,
    output logic              o_vram_ce,
    input  logic [DW-1:0]     i_vram_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] rd_tag, rd_tag_n;
    logic [PW-1:0]   start;

    // The current owner's own bit is excluded so a dropping owner never re-wins.
    arb_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req   (i_req & ~o_gnt),
        .start (start),
        .gnt   (pick)
    );

`ifdef VRAM_ARB_RR_EN
    logic [PW-1:0] last_q, gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++)
            if (gnt_n[k]) gnt_idx = PW'(k);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= PW'(NREQ - 1);
        else if (|gnt_n && (gnt_n != o_gnt))
            last_q <= gnt_idx;
    end

    assign start = (last_q >= PW'(NREQ - 1)) ? '0 : last_q + 1'b1;
`else
    assign start = '0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = o_gnt;
        case (state)
            ST_IDLE: begin
                if (|pick) begin
                    gnt_n   = pick;
                    state_n = ST_OWN;
                end
            end
            ST_OWN: begin
                // Owner released: hand off on this same edge, no idle bubble.
                if (!(|(o_gnt & i_req))) begin
                    gnt_n   = pick;
                    state_n = (|pick) ? ST_OWN : ST_IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Only a granted, still-requesting owner can launch an access.
    assign rd_tag_n = o_gnt & i_req & i_ce & ~i_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_gnt    <= '0;
            rd_tag   <= '0;
            o_rvalid <= '0;
            o_rdata  <= '0;
        end else begin
            state    <= state_n;
            o_gnt    <= gnt_n;
            rd_tag   <= rd_tag_n;
            o_rvalid <= rd_tag;
            if (|rd_tag) o_rdata <= i_vram_dout;
        end
    end

    always_comb begin
        o_vram_addr = '0;
        o_vram_din  = '0;
        o_vram_w    = 1'b0;
        o_vram_ce   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (o_gnt[k]) begin
                o_vram_addr = i_addr[k*AW +: AW];
                o_vram_din  = i_din[k*DW +: DW];
                o_vram_w    = i_we[k] & i_ce[k] & i_req[k];
                o_vram_ce   = i_ce[k] & i_req[k];
            end
        end
    end

    assign o_busy = |o_gnt;

endmodule
